// File: rtl/sar_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// sar_seq_ctrl_if
//   Bundle of control, comparator and result signals between the SAR sequencer
//   and its environment (analog front end model / consumer of the result).
//
//   Parameter:
//     NBITS    result / DAC word width
//
//   Signals (direction as seen by the sequencer, modport slave):
//     VENABLE  in   1 = advance, 0 = freeze all sequencer state
//     VSTART   in   conversion start request (accepted only in IDLE)
//     VCOMP    in   comparator decision, 1 = Vin >= Vdac
//     VSAMPLE  out  track/hold switch control
//     VBUSY    out  conversion in progress (SAMPLE or TRIAL)
//     VDAC     out  trial word for the capacitor DAC
//     DOUT     out  last completed result
//     VDONE    out  one-enabled-cycle completion pulse
//     VBIT     out  most recent bit decision
//     VBITVAL  out  one-enabled-cycle pulse after each decision
//
//   Modports:
//     master  environment side (drives VENABLE/VSTART/VCOMP)
//     slave   sequencer side
// -----------------------------------------------------------------------------
interface sar_seq_ctrl_if #(
  parameter int NBITS = 8
);

  logic             VENABLE;
  logic             VSTART;
  logic             VCOMP;
  logic             VSAMPLE;
  logic             VBUSY;
  logic [NBITS-1:0] VDAC;
  logic [NBITS-1:0] DOUT;
  logic             VDONE;
  logic             VBIT;
  logic             VBITVAL;

  modport master (
    output VENABLE, VSTART, VCOMP,
    input  VSAMPLE, VBUSY, VDAC, DOUT, VDONE, VBIT, VBITVAL
  );

  modport slave (
    input  VENABLE, VSTART, VCOMP,
    output VSAMPLE, VBUSY, VDAC, DOUT, VDONE, VBIT, VBITVAL
  );

endinterface

// File: rtl/sar_seq_ctrl.sv
// -----------------------------------------------------------------------------
// sar_seq_ctrl
//   Successive-approximation sequencer. Samples the input for SAMPLE_CYC
//   cycles, then resolves NBITS bits MSB-first, giving each trial SETTLE
//   cycles of DAC settling and taking the comparator decision on the last
//   one. Produces the parallel result plus a per-bit serial decision stream.
//
//   Parameters:
//     NBITS       result width (2..16)
//     SAMPLE_CYC  cycles spent with the track/hold switch closed (>=1)
//     SETTLE      cycles per bit trial (>=1)
//
//   Ports:
//     CLK     clock, all state changes on the rising edge
//     VRESET  synchronous active-high reset, dominates every other input
//     bus     sar_seq_ctrl_if.slave (enable, start, comparator in; DAC word,
//             result, status and bit-stream out)
// -----------------------------------------------------------------------------
module sar_seq_ctrl #(
  parameter int NBITS      = 8,
  parameter int SAMPLE_CYC = 2,
  parameter int SETTLE     = 1
) (
  input  logic          CLK,
  input  logic          VRESET,
  sar_seq_ctrl_if.slave bus
);

  localparam int IDXW = $clog2(NBITS);
  localparam int SCW  = (SAMPLE_CYC > 1) ? $clog2(SAMPLE_CYC) : 1;
  localparam int STW  = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [IDXW-1:0]  IDX_MSB     = IDXW'(NBITS - 1);
  localparam logic [SCW-1:0]   SAMPLE_LAST = SCW'(SAMPLE_CYC - 1);
  localparam logic [STW-1:0]   SETTLE_LAST = STW'(SETTLE - 1);
  localparam logic [NBITS-1:0] MSB_ONE     = {1'b1, {(NBITS-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    SAMPLE,
    TRIAL,
    DONE
  } state_t;

  state_t           state;
  logic [NBITS-1:0] work;
  logic [IDXW-1:0]  bit_idx;
  logic [SCW-1:0]   sample_cnt;
  logic [STW-1:0]   settle_cnt;

  logic             vsample_q;
  logic             vbusy_q;
  logic [NBITS-1:0] vdac_q;
  logic [NBITS-1:0] dout_q;
  logic             vdone_q;
  logic             vbit_q;
  logic             vbitval_q;

  logic [NBITS-1:0] decided;
  logic [NBITS-1:0] next_trial;

  // Working register with the current trial bit resolved by the comparator,
  // and the DAC word for the following trial (next lower bit forced to 1).
  // Bits below the current index are always still zero in the working register.
  always_comb begin
    decided          = work;
    decided[bit_idx] = bus.VCOMP;
    next_trial       = decided;
    if (bit_idx != '0) begin
      next_trial[bit_idx - IDXW'(1)] = 1'b1;
    end
  end

  // Single sequencer process. All outputs are registered and updated together
  // with the state, so they change only on enabled edges. The one-cycle pulses
  // are cleared only on enabled edges, which stretches them across a pause
  // instead of losing them.
  always_ff @(posedge CLK) begin
    if (VRESET) begin
      state      <= IDLE;
      work       <= '0;
      bit_idx    <= '0;
      sample_cnt <= '0;
      settle_cnt <= '0;
      vsample_q  <= 1'b0;
      vbusy_q    <= 1'b0;
      vdac_q     <= '0;
      dout_q     <= '0;
      vdone_q    <= 1'b0;
      vbit_q     <= 1'b0;
      vbitval_q  <= 1'b0;
    end else if (bus.VENABLE) begin
      vdone_q   <= 1'b0;
      vbitval_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.VSTART) begin
            state      <= SAMPLE;
            sample_cnt <= '0;
            work       <= '0;
            vsample_q  <= 1'b1;
            vbusy_q    <= 1'b1;
            vdac_q     <= '0;
          end
        end
        SAMPLE: begin
          if (sample_cnt == SAMPLE_LAST) begin
            state      <= TRIAL;
            bit_idx    <= IDX_MSB;
            settle_cnt <= '0;
            vsample_q  <= 1'b0;
            vdac_q     <= MSB_ONE;
          end else begin
            sample_cnt <= sample_cnt + SCW'(1);
          end
        end
        TRIAL: begin
          if (settle_cnt == SETTLE_LAST) begin
            work      <= decided;
            vbit_q    <= bus.VCOMP;
            vbitval_q <= 1'b1;
            if (bit_idx == '0) begin
              state   <= DONE;
              dout_q  <= decided;
              vdac_q  <= decided;
              vdone_q <= 1'b1;
              vbusy_q <= 1'b0;
            end else begin
              bit_idx    <= bit_idx - IDXW'(1);
              settle_cnt <= '0;
              vdac_q     <= next_trial;
            end
          end else begin
            settle_cnt <= settle_cnt + STW'(1);
          end
        end
        DONE: begin
          state  <= IDLE;
          vdac_q <= '0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.VSAMPLE = vsample_q;
  assign bus.VBUSY   = vbusy_q;
  assign bus.VDAC    = vdac_q;
  assign bus.DOUT    = dout_q;
  assign bus.VDONE   = vdone_q;
  assign bus.VBIT    = vbit_q;
  assign bus.VBITVAL = vbitval_q;

endmodule
